// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO and status/count registers
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ena,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wr_data,
    input  logic        i_mem_wr_ena,
    output logic        o_mmio_hit,
    output logic [31:0] o_mmio_rd_data,
    output logic        o_uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic            r_ovf;
    logic [31:0]     r_count;

    logic [3:0]      w_off;
    logic            w_wr;
    logic            w_push_req;
    logic            w_stat_wr;
    logic            w_cnt_wr;
    logic            w_empty;
    logic            w_full;
    logic            w_term;
    logic            w_pop;
    logic            w_push;
    logic            w_frame_done;
    logic [PW-1:0]   w_occ;
    logic [7:0]      w_rd_data;
    logic [31:0]     w_status;
    logic            w_unused;

    assign w_off        = i_mem_addr[3:0];
    assign o_mmio_hit   = i_mem_addr[31:4] == BASE_ADDR[31:4];
    assign w_wr         = i_ena & i_mem_wr_ena & o_mmio_hit;
    assign w_push_req   = w_wr & (w_off == 4'h0);
    assign w_stat_wr    = w_wr & (w_off == 4'h4);
    assign w_cnt_wr     = w_wr & (w_off == 4'h8);
    assign w_empty      = r_wr_ptr == r_rd_ptr;
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) & (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_term       = r_baud == BAUD_LAST;
    // A pop happens when the FSM is ready to load a new frame: from idle, or back-to-back at the end of a stop bit
    assign w_pop        = i_ena & ~w_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_term));
    // A push into a full FIFO still fits if a pop frees a slot in the same cycle
    assign w_push       = w_push_req & (~w_full | w_pop);
    assign w_frame_done = i_ena & (r_state == S_STOP) & w_term;
    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign w_rd_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_status     = {24'd0, 4'(w_occ), r_ovf, r_state != S_IDLE, w_empty, w_full};
    assign w_unused     = &{1'b0, i_mem_wr_data[31:8]};

    assign o_mmio_rd_data = !o_mmio_hit      ? 32'd0 :
                            (w_off == 4'h4)  ? w_status :
                            (w_off == 4'h8)  ? r_count : 32'd0;
    assign o_uart_tx      = r_tx;

    // FIFO pointers: push and pop are independent and may both occur in one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // FIFO storage needs no reset; contents are meaningless while the pointers say empty
    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_mem_wr_data[7:0];
    end

    // Sticky overflow flag: set by a dropped byte, cleared by any STATUS write
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_ovf <= 1'b0;
        else if (w_stat_wr)
            r_ovf <= 1'b0;
        else if (w_push_req & w_full & ~w_pop)
            r_ovf <= 1'b1;
    end

    // Completed-frame counter; a clearing write wins over a simultaneous frame completion
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_count <= 32'd0;
        else if (w_cnt_wr)
            r_count <= 32'd0;
        else if (w_frame_done)
            r_count <= r_count + 32'd1;
    end

    // TX FSM; the line flop follows the state one cycle later so each bit starts the cycle after entering it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else if (i_ena) begin
            r_tx <= (r_state == S_START) ? 1'b0 : (r_state == S_DATA) ? r_shift[0] : 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift <= w_rd_data;
                        r_baud  <= '0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_term) begin
                        r_baud  <= '0;
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (w_term) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= S_STOP;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (w_term) begin
                        r_baud <= '0;
                        if (!w_empty) begin
                            r_shift <= w_rd_data;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed and randomized checks of mmio_uart_tx against a frame-level reference model
module tb_mmio_uart_tx;
    localparam int C = 4;
    localparam int D = 4;
    localparam logic [31:0] BASE = 32'hF000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic        hit;
    logic [31:0] rdata;
    logic        tx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  q[$];
    logic [7:0]  cur;
    bit          busy;
    int          pos;
    bit          m_ovf;
    logic [31:0] m_cnt;
    logic        m_line;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena),
        .i_mem_addr(addr), .i_mem_wr_data(wdata), .i_mem_wr_ena(wr),
        .o_mmio_hit(hit), .o_mmio_rd_data(rdata), .o_uart_tx(tx)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit i of a frame on the wire: start, 8 data bits LSB first, stop
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        return (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
    endfunction

    function automatic logic [31:0] m_status();
        int n = q.size();
        return {24'd0, 4'(n), m_ovf, busy, n == 0, n == D};
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        if (a[3:0] == 4'h4) return m_status();
        if (a[3:0] == 4'h8) return m_cnt;
        return 32'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        busy = 0; pos = 0; cur = 8'd0; m_ovf = 0; m_cnt = 32'd0; m_line = 1'b1;
    endtask

    // One active clock edge of the transmitter seen as "a frame occupies 10*C cycles after its pop"
    task automatic model_edge(input logic en, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic nl;
        bit   pop;
        bit   hw;
        if (!en) return;
        nl  = busy ? frame_bit(cur, pos / C) : 1'b1;
        pop = 0;
        if (busy) begin
            if (pos == 10 * C - 1) begin
                m_cnt++;
                if (q.size() > 0) begin cur = q.pop_front(); pos = 0; pop = 1; end
                else busy = 0;
            end else pos++;
        end else if (q.size() > 0) begin
            cur = q.pop_front(); busy = 1; pos = 0; pop = 1;
        end
        hw = w && (a[31:4] == BASE[31:4]);
        if (hw && a[3:0] == 4'h0) begin
            if (q.size() < D) q.push_back(d[7:0]);
            else m_ovf = 1;
        end
        if (hw && a[3:0] == 4'h4) m_ovf = 0;
        if (hw && a[3:0] == 4'h8) m_cnt = 32'd0;
        m_line = nl;
    endtask

    // One clock cycle: drive after the falling edge, check combinational reads, clock, check the line
    task automatic cyc(input logic en, input logic w, input logic [31:0] a, input logic [31:0] d);
        ena = en; wr = w; addr = a; wdata = d;
        #1;
        check("hit", hit, {31'd0, a[31:4] == BASE[31:4]});
        check("rdata", rdata, m_rd(a));
        @(posedge clk);
        model_edge(en, w, a, d);
        @(negedge clk);
        check("line", tx, m_line);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        ena = 1'b1; wr = 1'b0; addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0: return BASE;
            1: return BASE + 32'h4;
            2: return BASE + 32'h8;
            3: return BASE + 32'hC;
            4: return BASE + 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, rand_addr(), 32'd0);
    endtask

    initial begin
        logic [9:0] a5_bits;
        a5_bits = 10'b11_0100_1010;
        rst_n = 1'b0; ena = 1'b1; wr = 1'b0; addr = BASE + 32'h4; wdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_line", tx, 1);
        check("rst_status", rdata, 32'h2);
        rst_n = 1'b1;
        rd("rst_count", BASE + 32'h8, 32'd0);

        cyc(1'b1, 1'b1, BASE, 32'h0000_00A5);
        idle(1);
        check("a5_late", tx, 1);
        for (int k = 0; k < 10; k++) begin
            idle(1);
            check("a5_bit", tx, {31'd0, a5_bits[k]});
            idle(3);
        end
        idle(2);
        rd("a5_count", BASE + 32'h8, 32'd1);
        rd("a5_status", BASE + 32'h4, 32'h2);

        cyc(1'b1, 1'b1, BASE + 32'h8, 32'd0);
        cyc(1'b1, 1'b1, BASE, 32'h01);
        cyc(1'b1, 1'b1, BASE, 32'h02);
        cyc(1'b1, 1'b1, BASE, 32'h03);
        for (int i = 0; i < 118; i++) begin
            cyc(1'b1, 1'b0, BASE + 32'h4, 32'd0);
            check("b2b_busy", rdata[2], 1);
        end
        idle(5);
        rd("b2b_count", BASE + 32'h8, 32'd3);

        cyc(1'b1, 1'b1, BASE + 32'h8, 32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, BASE, $urandom);
        rd("ovf_status", BASE + 32'h4, 32'h4D);
        cyc(1'b1, 1'b1, BASE + 32'h4, 32'd0);
        rd("ovf_clr", BASE + 32'h4, 32'h45);
        idle(210);
        rd("ovf_count", BASE + 32'h8, 32'd5);
        rd("ovf_idle", BASE + 32'h4, 32'h2);

        rd("map_status", BASE + 32'h4, 32'h2);
        check("map_hit", hit, 1);
        rd("map_miss", 32'h0000_1000, 32'd0);
        check("map_nohit", hit, 0);
        cyc(1'b1, 1'b1, BASE + 32'hC, 32'hFFFF_FFFF);
        idle(3);
        rd("rsv_status", BASE + 32'h4, 32'h2);
        rd("rsv_count", BASE + 32'h8, 32'd5);

        cyc(1'b1, 1'b1, BASE, 32'h3C);
        idle(12);
        repeat (10) cyc(1'b0, 1'b1, BASE, $urandom);
        idle(50);
        rd("ena_count", BASE + 32'h8, 32'd6);
        rd("ena_status", BASE + 32'h4, 32'h2);

        cyc(1'b1, 1'b1, BASE + 32'h8, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, BASE, 32'h00);
        check("prerst_line", tx, 0);
        rst_n = 1'b0;
        #1;
        check("async_rst_line", tx, 1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd("rst2_status", BASE + 32'h4, 32'h2);
        rd("rst2_count", BASE + 32'h8, 32'd0);
        idle(100);
        rd("rst2_after", BASE + 32'h8, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic en;
            logic w;
            logic [31:0] a;
            en = ($urandom_range(0, 9) != 0);
            w  = ($urandom_range(0, 5) == 0);
            a  = ($urandom_range(0, 9) < 6) ? BASE : rand_addr();
            cyc(en, w, a, $urandom);
        end
        idle(300);
        rd("final_status", BASE + 32'h4, m_status());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
